// File: rtl/matcher_pkg.sv
// Shared types and helpers for the vocabulary matcher: FSM states, the NUL
// terminator and per-character extraction from a packed word.
package matcher_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        CMP      = 3'd2,
        SKIP_RD  = 3'd3,
        SKIP_CMP = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam int NUL_CHAR   = 0;
    localparam int CHAR_MAX_W = 32;
    localparam int WORD_MAX_W = 1024;

    // Callers zero-extend their word to WORD_MAX_W and truncate the result to their char width.
    function automatic logic [CHAR_MAX_W-1:0] char_at(input logic [WORD_MAX_W-1:0] word,
                                                      input int idx,
                                                      input int data_width,
                                                      input int max_len);
        logic [WORD_MAX_W-1:0] sh;
        logic [CHAR_MAX_W-1:0] mask;
        if (idx >= max_len) return '0;
        sh   = word >> (idx * data_width);
        mask = (CHAR_MAX_W'(1) << data_width) - CHAR_MAX_W'(1);
        return sh[CHAR_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/vocab_matcher.sv
// Searches an external NUL-separated vocabulary for a word (exact or prefix match)
// and reports hit plus the ordinal token id of the matching entry.
module vocab_matcher
    import matcher_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_LEN    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [MAX_LEN*DATA_WIDTH-1:0] word,
    input  logic                          prefix_mode,
    input  logic [ADDR_WIDTH-1:0]         vocab_last,
    output logic                          vocab_rd,
    output logic [ADDR_WIDTH-1:0]         vocab_addr,
    input  logic [DATA_WIDTH-1:0]         vocab_rdata,
    output logic                          busy,
    output logic                          done,
    output logic                          hit,
    output logic [ADDR_WIDTH-1:0]         token_id,
    output logic [2:0]                    fsm_state
);

    localparam int CIW = $clog2(MAX_LEN + 1);
    localparam logic [DATA_WIDTH-1:0] NUL = DATA_WIDTH'(NUL_CHAR);

    state_t                        state, state_n;
    logic [ADDR_WIDTH-1:0]         addr, addr_n, addr_hold, tok, tok_n, token_id_n, last_q;
    logic [CIW-1:0]                ci, ci_n;
    logic [MAX_LEN*DATA_WIDTH-1:0] word_q;
    logic                          pmode_q, hit_n, at_last;
    logic [DATA_WIDTH-1:0]         in_ch, first_ch, v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            addr_hold <= '0;
            tok       <= '0;
            ci        <= '0;
            hit       <= 1'b0;
            token_id  <= '0;
            word_q    <= '0;
            pmode_q   <= 1'b0;
            last_q    <= '0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            tok      <= tok_n;
            ci       <= ci_n;
            hit      <= hit_n;
            token_id <= token_id_n;
            if (vocab_rd) addr_hold <= addr;
            if (state == IDLE && start) begin
                word_q  <= word;
                pmode_q <= prefix_mode;
                last_q  <= vocab_last;
            end
        end
    end

    assign in_ch    = DATA_WIDTH'(char_at(WORD_MAX_W'(word_q), int'(ci), DATA_WIDTH, MAX_LEN));
    assign first_ch = DATA_WIDTH'(char_at(WORD_MAX_W'(word), 0, DATA_WIDTH, MAX_LEN));
    assign v        = vocab_rdata;
    assign at_last  = (addr == last_q);

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        tok_n      = tok;
        ci_n       = ci;
        hit_n      = hit;
        token_id_n = token_id;
        vocab_rd   = 1'b0;
        case (state)
            IDLE: if (start) begin
                hit_n      = 1'b0;
                token_id_n = '0;
                addr_n     = '0;
                ci_n       = '0;
                tok_n      = '0;
                state_n    = (first_ch == NUL) ? DONE : RD;
            end
            RD: begin
                vocab_rd = 1'b1;
                state_n  = CMP;
            end
            SKIP_RD: begin
                vocab_rd = 1'b1;
                state_n  = SKIP_CMP;
            end
            CMP: begin
                // A hit outranks the vocab_last bound, so it is tested first.
                if (in_ch == NUL && (v == NUL || pmode_q)) begin
                    hit_n      = 1'b1;
                    token_id_n = tok;
                    state_n    = DONE;
                end else begin
                    if (!at_last) addr_n = addr + ADDR_WIDTH'(1);
                    if (v == in_ch) begin
                        ci_n    = ci + CIW'(1);
                        state_n = at_last ? DONE : RD;
                    end else if (v == NUL) begin
                        tok_n   = tok + ADDR_WIDTH'(1);
                        ci_n    = '0;
                        state_n = at_last ? DONE : RD;
                    end else begin
                        state_n = at_last ? DONE : SKIP_RD;
                    end
                end
            end
            SKIP_CMP: begin
                if (!at_last) addr_n = addr + ADDR_WIDTH'(1);
                if (v == NUL) begin
                    tok_n = tok + ADDR_WIDTH'(1);
                    ci_n  = '0;
                end
                state_n = at_last ? DONE : ((v == NUL) ? RD : SKIP_RD);
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign vocab_addr = vocab_rd ? addr : addr_hold;
    assign done       = (state == DONE);
    assign busy       = (state != IDLE);
    assign fsm_state  = state;

endmodule

// File: tb/tb_vocab_matcher.sv
// Directed bench for vocab_matcher: a driver queues expected {hit, token_id, latency}
// per search and an independent monitor checks them when done pulses.
module tb_vocab_matcher;

    logic        clk, rst_n, start, prefix_mode;
    logic [63:0] word;
    logic [7:0]  vocab_last, vocab_addr, vocab_rdata, token_id;
    logic        vocab_rd, busy, done, hit;
    logic [2:0]  fsm_state;

    vocab_matcher dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word(word), .prefix_mode(prefix_mode),
        .vocab_last(vocab_last), .vocab_rd(vocab_rd), .vocab_addr(vocab_addr),
        .vocab_rdata(vocab_rdata), .busy(busy), .done(done), .hit(hit),
        .token_id(token_id), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // vocabulary memory with one-cycle synchronous read
    logic [7:0] mem [256];
    always @(posedge clk) if (vocab_rd) vocab_rdata <= mem[vocab_addr];

    // scoreboard state: {hit, token_id[7:0], latency[7:0]}
    logic [16:0] exp_q[$];
    logic [7:0]  addr_log[$];
    int checks = 0, fails = 0, rd_count = 0, start_cyc = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        logic [16:0] e;
        if (vocab_rd) begin
            rd_count++;
            addr_log.push_back(vocab_addr);
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("hit", int'(hit), int'(e[16]));
                chk("token_id", int'(token_id), int'(e[15:8]));
                chk("latency", cyc - start_cyc + 1, int'(e[7:0]));
            end
        end
    end

    // driver helpers
    function automatic logic [63:0] make_word(input string s);
        logic [63:0] w = '0;
        for (int i = 0; i < s.len() && i < 8; i++) w[i*8 +: 8] = s[i];
        return w;
    endfunction

    // '|' in the string stands for the NUL terminator
    task automatic load_vocab(input string s);
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        for (int i = 0; i < s.len(); i++) mem[i] = (s[i] == 8'h7C) ? 8'h00 : s[i];
    endtask

    task automatic issue(input string w, input logic pm, input logic [7:0] last,
                         input logic eh, input logic [7:0] et, input int elat);
        @(negedge clk);
        word        = make_word(w);
        prefix_mode = pm;
        vocab_last  = last;
        start       = 1'b1;
        exp_q.push_back({eh, et, 8'(elat)});
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic search(input string w, input logic pm, input logic [7:0] last,
                          input logic eh, input logic [7:0] et, input int elat);
        issue(w, pm, last, eh, et, elat);
        wait_drain();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int rd0;
        rst_n = 1'b0; start = 1'b0; prefix_mode = 1'b0; word = '0; vocab_last = '0;
        load_vocab("ab|cd|");
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_token_id", int'(token_id), 0);
        chk("rst_vocab_rd", int'(vocab_rd), 0);
        chk("rst_vocab_addr", int'(vocab_addr), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // "cd" exact: skips entry 0, matches entry 1; addresses 0..5 each read once
        addr_log.delete();
        search("cd", 1'b0, 8'd5, 1'b1, 8'd1, 13);
        chk("cd_addr_count", addr_log.size(), 6);
        for (int i = 0; i < addr_log.size() && i < 6; i++) chk("cd_addr_seq", int'(addr_log[i]), i);
        repeat (3) @(negedge clk);
        chk("hold_hit", int'(hit), 1);
        chk("hold_token_id", int'(token_id), 1);

        search("ab", 1'b0, 8'd5, 1'b1, 8'd0, 7);
        // "c" exact: 'd' vs NUL mismatches, skip reaches vocab_last -> miss
        search("c", 1'b0, 8'd5, 1'b0, 8'd0, 13);
        search("c", 1'b1, 8'd5, 1'b1, 8'd1, 11);

        rd0 = rd_count;
        search("", 1'b0, 8'd5, 1'b0, 8'd0, 1);
        chk("empty_no_reads", rd_count - rd0, 0);

        // bound hit on 'b' before the terminator is read
        load_vocab("ab|");
        search("ab", 1'b0, 8'd1, 1'b0, 8'd0, 5);

        // full-length word with no terminator in the input
        load_vocab("abcdefgh|");
        search("abcdefgh", 1'b0, 8'd8, 1'b1, 8'd0, 19);

        // start while busy is ignored
        load_vocab("ab|cd|");
        issue("cd", 1'b0, 8'd5, 1'b1, 8'd1, 13);
        repeat (3) @(negedge clk);
        word = make_word("ab"); prefix_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (4) @(negedge clk);
        chk("busy_start_ignored_idle", int'(busy), 0);

        // reset mid-search aborts without done
        issue("cd", 1'b0, 8'd5, 1'b1, 8'd1, 13);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_hit", int'(hit), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        search("ab", 1'b0, 8'd5, 1'b1, 8'd0, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
